// File: rtl/difftest_arch_event_gen.sv
`timescale 1ns/1ps

// Generic circular FIFO; a write is accepted while full if a read leaves the same cycle.
// Latency: a written entry is readable from the edge it is written on (one cycle to rd_vld).
// Backpressure: wr_rdy drops when full and no read is pending; rd side holds data until rd_rdy.
module difftest_arch_event_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         wr_vld,
    output logic         wr_rdy,
    input  logic [W-1:0] wr_dat,
    output logic         rd_vld,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             full;
    logic             push;
    logic             pop;

    assign full   = (count == FULL_CNT);
    assign rd_vld = (count != '0);
    assign pop    = rd_vld && rd_rdy;
    // A pop in the same cycle frees the slot the push needs, so full+pop still accepts.
    assign wr_rdy = !full || pop;
    assign push   = wr_vld && wr_rdy;
    assign rd_dat = mem[rd_ptr];

    // Storage array; contents are only meaningful where count says so, so no reset needed.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// Captures core trap events into a FIFO and presents them one record at a time to the ArchEvent sink.
// Latency: event captured at edge N is on the outputs during cycle N+1; no combinational trap-to-out path.
// Backpressure: head record held stable while out_ready is low; events arriving while full are dropped and counted.
module difftest_arch_event_gen #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             trap_valid,
    input  logic             trap_is_int,
    input  logic [31:0]      trap_cause,
    input  logic [63:0]      trap_pc,
    input  logic [31:0]      trap_inst,
    input  logic             trap_nmi,
    input  logic             trap_hvictl,
    input  logic [7:0]       coreid,
    output logic             out_enable,
    input  logic             out_ready,
    output logic [31:0]      out_interrupt,
    output logic [31:0]      out_exception,
    output logic [63:0]      out_exception_pc,
    output logic [31:0]      out_exception_inst,
    output logic             out_has_nmi,
    output logic             out_vi_hvictl,
    output logic [7:0]       out_coreid,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_count
);
    typedef struct packed {
        logic        is_int;
        logic [31:0] cause;
        logic [63:0] pc;
        logic [31:0] inst;
        logic        nmi;
        logic        hvictl;
    } ev_t;

    localparam int EV_W = $bits(ev_t);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ev_t  trap_ev;
    ev_t  head_ev;
    logic head_vld;
    logic fifo_wr_rdy;
    logic drop;

    assign trap_ev = '{
        is_int: trap_is_int,
        cause:  trap_cause,
        pc:     trap_pc,
        inst:   trap_inst,
        nmi:    trap_nmi,
        hvictl: trap_hvictl
    };

    difftest_arch_event_fifo #(
        .DEPTH (DEPTH),
        .W     (EV_W)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .wr_vld  (trap_valid),
        .wr_rdy  (fifo_wr_rdy),
        .wr_dat  (trap_ev),
        .rd_vld  (head_vld),
        .rd_rdy  (out_ready),
        .rd_dat  (head_ev)
    );

    // An event is lost only when the FIFO is full and nothing leaves this cycle.
    assign drop = trap_valid && !fifo_wr_rdy;

    // Sticky overflow flag and saturating drop counter; only reset clears them.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != CNT_MAX) begin
                drop_count <= drop_count + CNT_W'(1);
            end
        end
    end

    // Head record mapping; all data forced to zero when no record is offered so the sink never sees stale bits.
    always_comb begin
        out_enable         = head_vld;
        out_interrupt      = 32'd0;
        out_exception      = 32'd0;
        out_exception_pc   = 64'd0;
        out_exception_inst = 32'd0;
        out_has_nmi        = 1'b0;
        out_vi_hvictl      = 1'b0;
        if (head_vld) begin
            out_interrupt      = head_ev.is_int ? head_ev.cause : 32'd0;
            out_exception      = head_ev.is_int ? 32'd0 : head_ev.cause;
            out_exception_pc   = head_ev.pc;
            out_exception_inst = head_ev.inst;
            out_has_nmi        = head_ev.nmi;
            out_vi_hvictl      = head_ev.hvictl;
        end
    end

    assign out_coreid = coreid;

endmodule

// File: tb/tb_difftest_arch_event_gen.sv
`timescale 1ns/1ps

module tb_difftest_arch_event_gen;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        logic        is_int;
        logic [31:0] cause;
        logic [63:0] pc;
        logic [31:0] inst;
        logic        nmi;
        logic        hvictl;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             trap_valid;
    logic             trap_is_int;
    logic [31:0]      trap_cause;
    logic [63:0]      trap_pc;
    logic [31:0]      trap_inst;
    logic             trap_nmi;
    logic             trap_hvictl;
    logic [7:0]       coreid;
    logic             out_enable;
    logic             out_ready;
    logic [31:0]      out_interrupt;
    logic [31:0]      out_exception;
    logic [63:0]      out_exception_pc;
    logic [31:0]      out_exception_inst;
    logic             out_has_nmi;
    logic             out_vi_hvictl;
    logic [7:0]       out_coreid;
    logic             overflow;
    logic [CNT_W-1:0] drop_count;

    exp_t        q[$];
    logic [31:0] rx[$];
    int          checks = 0;
    int          errors = 0;
    bit          m_ovf  = 1'b0;
    int          m_drops = 0;

    always #5 clock = ~clock;

    difftest_arch_event_gen #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .trap_valid         (trap_valid),
        .trap_is_int        (trap_is_int),
        .trap_cause         (trap_cause),
        .trap_pc            (trap_pc),
        .trap_inst          (trap_inst),
        .trap_nmi           (trap_nmi),
        .trap_hvictl        (trap_hvictl),
        .coreid             (coreid),
        .out_enable         (out_enable),
        .out_ready          (out_ready),
        .out_interrupt      (out_interrupt),
        .out_exception      (out_exception),
        .out_exception_pc   (out_exception_pc),
        .out_exception_inst (out_exception_inst),
        .out_has_nmi        (out_has_nmi),
        .out_vi_hvictl      (out_vi_hvictl),
        .out_coreid         (out_coreid),
        .overflow           (overflow),
        .drop_count         (drop_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_trap(input logic v, input logic is_int, input logic [31:0] cause,
                            input logic [63:0] pc, input logic [31:0] inst,
                            input logic nmi, input logic hv);
        trap_valid  = v;
        trap_is_int = is_int;
        trap_cause  = cause;
        trap_pc     = pc;
        trap_inst   = inst;
        trap_nmi    = nmi;
        trap_hvictl = hv;
    endtask

    task automatic idle();
        set_trap(1'b0, 1'b0, 32'd0, 64'd0, 32'd0, 1'b0, 1'b0);
    endtask

    // Compare outputs against the scoreboard head, apply this cycle's pop/push to the model, advance one clock.
    task automatic cycle();
        exp_t e;
        chk("out_enable", 64'(out_enable), 64'(q.size() != 0));
        chk("out_coreid", 64'(out_coreid), 64'(coreid));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("drop_count", 64'(drop_count), 64'(m_drops));
        if (out_enable && out_ready) begin
            rx.push_back(out_exception | out_interrupt);
        end
        if (q.size() != 0) begin
            e = q[0];
            chk("out_interrupt", 64'(out_interrupt), e.is_int ? 64'(e.cause) : 64'd0);
            chk("out_exception", 64'(out_exception), e.is_int ? 64'd0 : 64'(e.cause));
            chk("out_exception_pc", out_exception_pc, e.pc);
            chk("out_exception_inst", 64'(out_exception_inst), 64'(e.inst));
            chk("out_has_nmi", 64'(out_has_nmi), 64'(e.nmi));
            chk("out_vi_hvictl", 64'(out_vi_hvictl), 64'(e.hvictl));
            if (out_ready) begin
                void'(q.pop_front());
            end
        end else begin
            chk("idle_data", {out_interrupt, out_exception} | out_exception_pc
                | 64'(out_exception_inst) | 64'({out_has_nmi, out_vi_hvictl}), 64'd0);
        end
        if (trap_valid) begin
            if (q.size() < DEPTH) begin
                e.is_int = trap_is_int;
                e.cause  = trap_cause;
                e.pc     = trap_pc;
                e.inst   = trap_inst;
                e.nmi    = trap_nmi;
                e.hvictl = trap_hvictl;
                q.push_back(e);
            end else begin
                m_ovf = 1'b1;
                if (m_drops != CNT_MAX) m_drops++;
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        out_ready = 1'b0;
        coreid    = 8'h5A;
        idle();
        repeat (3) @(posedge clock);
        #1;
        chk("rst_out_enable", 64'(out_enable), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_drop_count", 64'(drop_count), 64'd0);
        chk("rst_data", {out_interrupt, out_exception} | out_exception_pc, 64'd0);
        chk("rst_coreid", 64'(out_coreid), 64'h5A);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        cycle();

        // single exception
        out_ready = 1'b1;
        set_trap(1'b1, 1'b0, 32'd2, 64'h8000_0010, 32'hFFFF_FFFF, 1'b0, 1'b0);
        cycle();
        idle();
        cycle();
        cycle();

        // interrupt with nmi and hvictl flags
        set_trap(1'b1, 1'b1, 32'd7, 64'h8000_0100, 32'h0000_0073, 1'b1, 1'b1);
        cycle();
        idle();
        cycle();
        cycle();

        // back-pressure: fill, hold, then drain one per cycle
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            set_trap(1'b1, 1'b0, 32'(i), 64'h1000 + 64'(i * 4), 32'h13 + 32'(i), 1'b0, 1'b0);
            cycle();
        end
        idle();
        cycle();
        cycle();
        out_ready = 1'b1;
        repeat (5) cycle();

        // overflow: fill, drop five (counter saturates), then full with pop plus push
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            set_trap(1'b1, 1'b0, 32'h20 + 32'(i), 64'h2000 + 64'(i * 4), 32'hA0 + 32'(i), 1'b0, 1'b0);
            cycle();
        end
        for (int i = 0; i < 5; i++) begin
            set_trap(1'b1, 1'b1, 32'h40 + 32'(i), 64'h4000 + 64'(i * 4), 32'hB0 + 32'(i), 1'b1, 1'b0);
            cycle();
        end
        out_ready = 1'b1;
        set_trap(1'b1, 1'b1, 32'h50, 64'h5000, 32'hC0, 1'b1, 1'b0);
        cycle();
        idle();
        repeat (6) cycle();

        // wrap-around stream with toggling ready
        rx.delete();
        for (int i = 0; i < 20; i++) begin
            out_ready = (i % 2 == 0);
            if (i % 2 == 0) begin
                set_trap(1'b1, 1'b0, 32'h100 + 32'(i / 2), {32'hC000_0000, $urandom}, $urandom, 1'b0, 1'b0);
            end else begin
                idle();
            end
            cycle();
        end
        idle();
        out_ready = 1'b1;
        repeat (3) cycle();
        chk("wrap_rx_count", 64'(rx.size()), 64'd10);
        for (int i = 0; i < 10 && i < rx.size(); i++) begin
            chk("wrap_rx_order", 64'(rx[i]), 64'h100 + 64'(i));
        end

        // reset mid-stream with three entries buffered
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            set_trap(1'b1, 1'b0, 32'h60 + 32'(i), 64'h6000 + 64'(i * 4), 32'hD0 + 32'(i), 1'b0, 1'b0);
            cycle();
        end
        idle();
        reset_n = 1'b0;
        #2;
        chk("mid_rst_out_enable", 64'(out_enable), 64'd0);
        chk("mid_rst_drop_count", 64'(drop_count), 64'd0);
        chk("mid_rst_overflow", 64'(overflow), 64'd0);
        chk("mid_rst_exception", 64'(out_exception), 64'd0);
        q.delete();
        m_ovf   = 1'b0;
        m_drops = 0;
        @(posedge clock);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        repeat (3) cycle();
        set_trap(1'b1, 1'b0, 32'h77, 64'h7000, 32'hE0, 1'b0, 1'b0);
        cycle();
        idle();
        cycle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/difftest_arch_event_gen.md
# difftest_arch_event_gen

Producer side of the difftest ArchEvent channel. It captures trap events (interrupts, exceptions, NMIs) from the core's commit/trap unit. It buffers them in a small FIFO and presents one record at a time, with a valid/ready handshake, to the DPI-backed ArchEvent sink. It sits between the core's trap logic and the difftest sink, so a back-pressured sink never loses or reorders events.

## Interface
- DEPTH, 4, FIFO entries; power of two, minimum 2
- CNT_W, 16, width of the saturating drop counter
- clock  in  1  sole clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- trap_valid  in  1  one trap event presented this cycle
- trap_is_int  in  1  1 = interrupt, 0 = exception
- trap_cause  in  32  cause code (mcause without MSB)
- trap_pc  in  64  PC of the trapping instruction
- trap_inst  in  32  instruction bits at trap_pc
- trap_nmi  in  1  event is an NMI
- trap_hvictl  in  1  virtual interrupt injected via hvictl
- coreid  in  8  static hart id, passed through
- out_enable  out  1  record valid toward the sink
- out_ready  in  1  sink accepts the record this cycle
- out_interrupt  out  32  cause if interrupt, else 0
- out_exception  out  32  cause if exception, else 0
- out_exception_pc  out  64  trap_pc of the head record
- out_exception_inst  out  32  trap_inst of the head record
- out_has_nmi  out  1  head record NMI flag
- out_vi_hvictl  out  1  head record hvictl-inject flag
- out_coreid  out  8  equals coreid, combinational
- overflow  out  1  sticky; set when any event is dropped
- drop_count  out  CNT_W  number of dropped events, saturating

## Operation
- Storage: DEPTH-entry circular FIFO of {is_int, cause, pc, inst, nmi, hvictl}. Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy count is log2(DEPTH)+1 bits.
- Push: when trap_valid is high and the FIFO is not full, or is full with a pop in the same cycle.
- Pop: when out_enable && out_ready.
- Ordering: strictly FIFO; records leave in capture order.
- Output mapping from the head entry:
  - out_interrupt = is_int ? cause : 0
  - out_exception = is_int ? 0 : cause
  - other fields copied unchanged.
- out_enable = (count != 0). All out_* fields are held stable while out_enable && !out_ready.
- When out_enable is 0, all out_* data outputs are 0 except out_coreid.
- Drop: trap_valid while full with no pop in the same cycle.
  - The new event is discarded; the FIFO contents are unchanged.
  - overflow is set to 1.
  - drop_count increments by 1, saturating at 2^CNT_W-1.
- overflow and drop_count clear only on reset.
- Push and pop in the same cycle on an empty FIFO: not possible. out_enable is 0, so no pop occurs, and the push is accepted.

## Timing
- Reset (async assert, sync release): pointers, count, overflow and drop_count = 0. out_enable = 0, all data outputs = 0, out_coreid = coreid.
- Reset asserted mid-operation: all buffered events are discarded immediately; no partial record is emitted afterwards.
- Latency: an event captured at edge N drives out_enable=1 from edge N onward, i.e. it is visible in cycle N+1. There is no combinational trap→out path.
- Throughput: one push and one pop per cycle. With out_ready held at 1, one record per cycle.
- A record is consumed at the edge where out_enable && out_ready are both high. The next entry, if any, appears in the following cycle.
- Full plus simultaneous push and pop: both happen and count stays at DEPTH. No drop is recorded.
- Pointer wrap from DEPTH-1 to 0 requires no bubble.

## Test plan
- Single exception: trap_valid=1, is_int=0, cause=2, pc=0x8000_0010, inst=0xFFFF_FFFF, with out_ready=1. Next cycle: out_enable=1, out_exception=2, out_interrupt=0, pc and inst match. The cycle after: out_enable=0.
- Interrupt with flags: is_int=1, cause=7, nmi=1, hvictl=1 → out_interrupt=7, out_exception=0, out_has_nmi=1, out_vi_hvictl=1.
- Back-pressure: out_ready=0 while pushing 4 events with causes 1..4 (DEPTH=4). The head stays at cause 1 and is stable. Then raise out_ready: causes 1,2,3,4 emerge on consecutive cycles.
- Overflow: with the FIFO full and out_ready=0, push 3 more events → overflow=1, drop_count=3, and the FIFO still holds the original 4 in order. Next, full with out_ready=1 plus a push → no drop, count stays 4.
- Wrap-around: stream 10 events with out_ready toggling 1,0,1,0… → all 10 are received in order with no duplicates.
- Reset mid-stream: assert reset_n=0 with 3 entries buffered → out_enable=0 and drop_count=0 asynchronously. After release, nothing is emitted until a new trap_valid.
